// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: CPU writes bytes to BASE_ADDR, status is read back at BASE_ADDR+1.
// Build option UART_TX_FIFO_EN selects an 8-entry FIFO; without it a single holding register is used.
module uart_tx_port #(
    parameter logic [15:0] BASE_ADDR = 16'h5a00,
    parameter int unsigned CLK_DIV   = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] addressBus,
    input  logic        writeEnBus,
    input  logic [7:0]  data_c2r,
    output logic [7:0]  data_out,
    output logic        rd_sel,
    output logic        txd
);

`ifdef UART_TX_FIFO_EN
    localparam int unsigned DEPTH = 8;
`else
    localparam int unsigned DEPTH = 1;
`endif

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned MEM_N = 1 << PTR_W;
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [15:0]      STAT_ADDR = BASE_ADDR + 16'd1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] bitcnt_q, bitcnt_d;
    logic [2:0]       bitidx_q, bitidx_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;

    logic [7:0]       mem_q [MEM_N];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovr_q, ovr_d;

    logic             data_wr, stat_wr;
    logic             buf_empty, buf_full;
    logic             push, pop;
    logic             bit_done;
    logic [7:0]       status;

    assign data_wr   = writeEnBus && (addressBus == BASE_ADDR);
    assign stat_wr   = writeEnBus && (addressBus == STAT_ADDR);
    assign buf_empty = (count_q == '0);
    assign buf_full  = (count_q == CNT_FULL);
    assign bit_done  = (bitcnt_q == '0);

    // A pop frees a slot at the same edge, so a write to a full buffer still lands.
    assign push = data_wr && (!buf_full || pop);

    // Transmitter next state; the bit counter counts down the remainder of the current bit.
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        bitidx_d = bitidx_q;
        shift_d  = shift_q;
        pop      = 1'b0;
        if (state_q != S_IDLE && !bit_done) begin
            bitcnt_d = bitcnt_q - DIV_W'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (!buf_empty) begin
                    pop      = 1'b1;
                    shift_d  = mem_q[rd_ptr_q];
                    bitcnt_d = DIV_LAST;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (bit_done) begin
                    bitidx_d = 3'd0;
                    bitcnt_d = DIV_LAST;
                    state_d  = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    bitcnt_d = DIV_LAST;
                    shift_d  = {1'b0, shift_q[7:1]};
                    if (bitidx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bitidx_d = bitidx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    if (!buf_empty) begin
                        pop      = 1'b1;
                        shift_d  = mem_q[rd_ptr_q];
                        bitcnt_d = DIV_LAST;
                        state_d  = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // txd is registered from the next state so the line never glitches.
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovr_d    = ovr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (stat_wr) begin
            ovr_d = 1'b0;
        end else if (data_wr && !push) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            bitcnt_q <= '0;
            bitidx_q <= 3'd0;
            shift_q  <= 8'h00;
            txd_q    <= 1'b1;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            bitidx_q <= bitidx_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovr_q    <= ovr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset && push) begin
            mem_q[wr_ptr_q] <= data_c2r;
        end
    end

    assign status   = {4'b0000, ovr_q, buf_empty, buf_full, (state_q != S_IDLE)};
    assign data_out = (addressBus == STAT_ADDR) ? status : 8'h00;
    assign rd_sel   = (addressBus == BASE_ADDR) || (addressBus == STAT_ADDR);
    assign txd      = txd_q;

endmodule

// File: tb/tb_uart_tx_port.sv
// Bench for uart_tx_port at CLK_DIV=4: frame-position model compared every cycle, plus directed frames/status literals.
`timescale 1ns/1ps
module tb_uart_tx_port;

    localparam int          CLK_DIV = 4;
    localparam int          FRAME   = 10 * CLK_DIV;
    localparam logic [15:0] BASE    = 16'h5a00;
    localparam logic [15:0] STAT    = 16'h5a01;
`ifdef UART_TX_FIFO_EN
    localparam int DEPTH = 8;
`else
    localparam int DEPTH = 1;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] addressBus = 16'h0000;
    logic        writeEnBus = 1'b0;
    logic [7:0]  data_c2r = 8'h00;
    logic [7:0]  data_out;
    logic        rd_sel;
    logic        txd;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    uart_tx_port #(.BASE_ADDR(BASE), .CLK_DIV(CLK_DIV)) dut (
        .clock      (clock),
        .reset      (reset),
        .addressBus (addressBus),
        .writeEnBus (writeEnBus),
        .data_c2r   (data_c2r),
        .data_out   (data_out),
        .rd_sel     (rd_sel),
        .txd        (txd)
    );

    always #5 clock = ~clock;

    // Reference model: a byte queue plus the position inside the current frame.
    logic [7:0] m_q [$];
    bit         m_active = 1'b0;
    int         m_pos    = 0;
    logic [7:0] m_byte   = 8'h00;
    bit         m_ovr    = 1'b0;

    task automatic model_step();
        bit do_pop;
        bit was_full;
        if (!reset) begin
            m_q.delete();
            m_active = 1'b0;
            m_pos    = 0;
            m_ovr    = 1'b0;
            return;
        end
        was_full = (m_q.size() == DEPTH);
        do_pop   = 1'b0;
        if (!m_active || m_pos == FRAME - 1) begin
            if (m_q.size() > 0) begin
                do_pop   = 1'b1;
                m_byte   = m_q.pop_front();
                m_active = 1'b1;
                m_pos    = 0;
            end else begin
                m_active = 1'b0;
                m_pos    = 0;
            end
        end else begin
            m_pos++;
        end
        if (writeEnBus && addressBus == BASE) begin
            if (!was_full || do_pop) m_q.push_back(data_c2r);
            else m_ovr = 1'b1;
        end else if (writeEnBus && addressBus == STAT) begin
            m_ovr = 1'b0;
        end
    endtask

    function automatic logic m_txd();
        int idx;
        if (!m_active) return 1'b1;
        idx = m_pos / CLK_DIV;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return m_byte[idx-1];
    endfunction

    function automatic logic [7:0] m_status();
        return {4'b0000, m_ovr, (m_q.size() == 0), (m_q.size() == DEPTH), m_active};
    endfunction

    always @(posedge clock) model_step();

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            check("txd", 16'(txd), 16'(m_txd()));
            check("data_out", 16'(data_out), (addressBus == STAT) ? 16'(m_status()) : 16'h0000);
            check("rd_sel", 16'(rd_sel), 16'((addressBus == BASE) || (addressBus == STAT)));
        end
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic drive(logic we, logic [15:0] a, logic [7:0] d);
        writeEnBus = we;
        addressBus = a;
        data_c2r   = d;
    endtask

    // One byte 8'h48 into an idle block; bits listed in line order.
    task automatic single_frame();
        bit exp_bits [10] = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 1};
        logic [7:0] st_queued;
        st_queued = (DEPTH == 1) ? 8'h02 : 8'h00;
        for (int j = 0; j <= 42; j++) begin
            step();
            if (j == 0) drive(1'b1, BASE, 8'h48);
            else drive(1'b0, STAT, 8'h00);
            #1;
            if (j == 1) begin
                check("queued_status", 16'(data_out), 16'(st_queued));
                check("idle_txd", 16'(txd), 16'h0001);
            end
            if (j >= 2 && j <= 41) check("frame48_bit", 16'(txd), 16'(exp_bits[(j-2)/CLK_DIV]));
            if (j == 41) check("stop_busy", 16'(data_out), 16'h0005);
            if (j == 42) begin
                check("after_frame_status", 16'(data_out), 16'h0004);
                check("after_frame_txd", 16'(txd), 16'h0001);
            end
        end
    endtask

    // Back-to-back writes from 'first', overrun clear at clr_j, then decode nf frames at mid-bit.
    task automatic burst(int nw, logic [7:0] first, int nf, int clr_j);
        logic [9:0] rx [16];
        int last_j;
        int k;
        last_j = 2 + FRAME * nf;
        for (int i = 0; i < 16; i++) rx[i] = '0;
        for (int j = 0; j <= last_j; j++) begin
            step();
            if (j < nw) drive(1'b1, BASE, first + 8'(j));
            else if (j == clr_j) drive(1'b1, STAT, 8'($urandom_range(0, 255)));
            else drive(1'b0, STAT, 8'h00);
            #1;
            if (j == nw) check("burst_status", 16'(data_out), 16'h000b);
            if (j == clr_j + 1) check("ovr_cleared", 16'(data_out), 16'h0003);
            if (j == last_j) check("drained_status", 16'(data_out), 16'h0004);
            if (j >= 2 + CLK_DIV / 2 && (j - 2 - CLK_DIV / 2) % CLK_DIV == 0) begin
                k = (j - 2 - CLK_DIV / 2) / CLK_DIV;
                if (k < 10 * nf) rx[k / 10][k % 10] = txd;
            end
        end
        for (int f = 0; f < nf; f++) check("frame_rx", 16'(rx[f]), 16'({1'b1, first + 8'(f), 1'b0}));
    endtask

    task automatic reset_mid_frame();
        for (int j = 0; j <= 120; j++) begin
            step();
            reset = 1'b1;
            if (j == 0) drive(1'b1, BASE, 8'hc3);
            else if (j == 1) drive(1'b1, BASE, 8'h96);
            else if (j == 15) begin
                reset = 1'b0;
                drive(1'b1, BASE, 8'h77);
            end else drive(1'b0, STAT, 8'h00);
            #1;
            if (j == 14) check("mid_data_txd", 16'(txd), 16'h0000);
            if (j == 16) begin
                check("reset_txd", 16'(txd), 16'h0001);
                check("reset_status", 16'(data_out), 16'h0004);
            end
            if (j == 120) begin
                check("no_frames_txd", 16'(txd), 16'h0001);
                check("no_frames_status", 16'(data_out), 16'h0004);
            end
        end
    endtask

    task automatic foreign_addr();
        bit saw_low;
        step(); drive(1'b1, 16'h5b00, 8'h5a); #1;
        step(); drive(1'b0, 16'h5a02, 8'h00); #1;
        check("foreign_dout", 16'(data_out), 16'h0000);
        check("foreign_rdsel", 16'(rd_sel), 16'h0000);
        drive(1'b0, BASE, 8'h00); #1;
        check("base_rdsel", 16'(rd_sel), 16'h0001);
        check("base_dout", 16'(data_out), 16'h0000);
        saw_low = 1'b0;
        for (int j = 0; j < 50; j++) begin
            step(); drive(1'b0, STAT, 8'h00); #1;
            if (txd !== 1'b1) saw_low = 1'b1;
        end
        check("foreign_no_frame", 16'(saw_low), 16'h0000);
        check("foreign_status", 16'(data_out), 16'h0004);
    endtask

    task automatic random_phase(int cycles);
        int wr_pct;
        int sel;
        logic [15:0] a;
        wr_pct = 30;
        for (int n = 0; n < cycles; n++) begin
            step();
            if (n % 200 == 0) begin
                sel = $urandom_range(0, 2);
                wr_pct = (sel == 0) ? 5 : (sel == 1) ? 30 : 90;
            end
            reset = ($urandom_range(0, 199) != 0);
            sel = $urandom_range(0, 5);
            case (sel)
                0, 1, 2: a = BASE;
                3:       a = STAT;
                4:       a = 16'h5a02;
                default: a = 16'($urandom());
            endcase
            drive(($urandom_range(0, 99) < wr_pct), a, 8'($urandom()));
        end
        step();
        reset = 1'b1;
        drive(1'b0, STAT, 8'h00);
    endtask

    initial begin
        reset = 1'b0;
        step();
        chk_en = 1'b1;
        check("reset_txd0", 16'(txd), 16'h0001);
        step();
        step();
        reset = 1'b1;
        drive(1'b0, STAT, 8'h00);
        #1;
        check("reset_status0", 16'(data_out), 16'h0004);
        single_frame();
`ifdef UART_TX_FIFO_EN
        burst(10, 8'h41, 9, 11);
`else
        burst(3, 8'h31, 2, 5);
`endif
        reset_mid_frame();
        foreign_addr();
        random_phase(2500);
        for (int j = 0; j < 5; j++) step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_port.md
UART_TX_PORT -- requirements
Module: uart_tx_port

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'h5a00: data register address; status register at BASE_ADDR+1.
REQ-002 SHALL have parameter CLK_DIV, default 16: clock cycles per serial bit (legal range 2..65535).
REQ-003 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-low (0 = reset).
REQ-005 SHALL have port addressBus  input  16  CPU address.
REQ-006 SHALL have port writeEnBus  input  1  CPU write strobe, one cycle per write.
REQ-007 SHALL have port data_c2r  input  8  CPU write data.
REQ-008 SHALL have port data_out  output  8  read data for the CPU-side read mux.
REQ-009 SHALL have port rd_sel  output  1  high when addressBus is BASE_ADDR or BASE_ADDR+1 (combinational).
REQ-010 SHALL have port txd  output  1  serial line, idle high.

Function
REQ-011 SHALL accept a byte at a rising edge where writeEnBus=1, addressBus=BASE_ADDR and buffer not full.
REQ-012 SHALL drop a data write when the buffer is full, and set sticky status bit overrun.
REQ-013 SHALL accept a data write even when full if a pop occurs at the same edge; count stays unchanged.
REQ-014 SHALL clear overrun on any write to BASE_ADDR+1, whatever the data value.
REQ-015 SHALL ignore writes to all other addresses.
REQ-016 SHALL drive data_out = status when addressBus=BASE_ADDR+1: bit0 busy, bit1 full, bit2 empty, bit3 overrun, bits7:4 zero.
REQ-017 SHALL drive data_out = 8'h00 at every other address.
REQ-018 SHALL run transmitter FSM IDLE -> START -> DATA -> STOP -> IDLE.
REQ-019 SHALL go IDLE -> START at the first edge where the buffer is non-empty, popping the head byte into the shift register.
REQ-020 SHALL make txd low for the START bit; a byte written at edge N into an empty, idle block drives txd=0 after edge N+1.
REQ-021 SHALL hold each of START, the 8 DATA bits and STOP for exactly CLK_DIV cycles, using a bit-time counter reloaded on every bit.
REQ-022 SHALL send DATA LSB first, then STOP with txd=1, for a frame of 10*CLK_DIV cycles.
REQ-023 SHALL, at the end of STOP, go to START when buffer non-empty, giving back-to-back frames with no idle gap; otherwise go to IDLE.
REQ-024 SHALL set busy=1 in any state other than IDLE.
REQ-025 SHALL wrap FIFO read/write pointers modulo depth, with count 0..depth.

Reset
REQ-026 SHALL, on any edge with reset=0, force FSM to IDLE, txd=1, buffer empty, pointers and count 0, overrun 0, and the bit counter 0.
REQ-027 SHALL abort a frame in progress on reset mid-frame; txd goes high after that edge, and queued bytes are discarded.
REQ-028 SHALL ignore writes at edges where reset=0.

Configuration
REQ-029 SHALL, when UART_TX_FIFO_EN is defined, buffer bytes in an 8-entry FIFO (full at count 8).
REQ-030 SHALL, when UART_TX_FIFO_EN is undefined, use a single holding register (depth 1, full at count 1); all other behaviour is unchanged.

Verification
REQ-031 SHALL test: CLK_DIV=4, write 8'h48 to 16'h5a00 -> txd 0 for 4 cycles, then 0,0,0,1,0,0,1,0 at 4 cycles each, then 1; busy=0 40 cycles after START.
REQ-032 SHALL test: FIFO_EN, 10 back-to-back writes 8'h41..8'h4a -> first byte popped, next 8 queued, 8'h4a dropped; status reads 8'h0b; txd shows 9 contiguous frames 8'h41..8'h49.
REQ-033 SHALL test: after REQ-032, write 8'h00 to 16'h5a01 -> overrun=0; after the frames drain, status = 8'h04.
REQ-034 SHALL test: assert reset=0 for one cycle mid-DATA -> txd=1 after that edge, status=8'h04, and no further frames.
REQ-035 SHALL test: write 8'h5a to 16'h5b00 and read 16'h5a02 -> no frame, data_out=8'h00, rd_sel=0.
REQ-036 SHALL test: FIFO_EN undefined, writes 8'h31 then 8'h32 on consecutive edges -> both sent (one popped, one held); a third write in the next cycle is dropped with overrun=1.
